// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte producers, one byte per grant.
// Optional watchdog in WAIT_RDY enabled by defining UART_ARB_TIMEOUT_EN (adds err_o).
module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_rdy_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      err_o
`endif
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_RDY, DONE} state_t;

  state_t              state_q;
  logic [OW-1:0]       rr_ptr_q;
  logic [OW-1:0]       rr_ptr_d;
  logic [OW-1:0]       owner_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic                start_q;
  logic                busy_q;

  logic                pick_vld;
  logic [OW-1:0]       pick_idx;
  logic [DATA_W-1:0]   pick_dat;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  // Scan offsets from the highest down so the smallest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      logic [OW:0] cand;
      cand = {1'b0, rr_ptr_q} + (OW+1)'(i);
      if (cand >= (OW+1)'(N_REQ)) begin
        cand = cand - (OW+1)'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (req_i[j] && (cand == (OW+1)'(j))) begin
          pick_vld = 1'b1;
          pick_idx = OW'(j);
        end
      end
    end
  end

  assign pick_dat = data_i[pick_idx*DATA_W +: DATA_W];
  assign rr_ptr_d = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      tx_data_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q   <= pick_idx;
            tx_data_q <= pick_dat;
            gnt_q     <= ONE_HOT0 << pick_idx;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          state_q <= WAIT_RDY;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT_RDY: begin
          if (tx_rdy_i) begin
            done_q  <= ONE_HOT0 << owner_q;
            state_q <= DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            done_q  <= ONE_HOT0 << owner_q;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign tx_start_o = start_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err_o      = err_q;
`endif

endmodule
